// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: holds the PC, reads one opcode byte per instruction, presents it to control_unit.
// Latency: 3 cycles from reset release or from an accepted i_next_instr to a valid opcode (FETCH, WAIT, capture).
// Backpressure: the opcode is held with valid until i_next_instr is seen in EXEC; requests elsewhere are dropped.
module fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_next_instr,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_value,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_opcode,
  output logic              o_opcode_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_opcode;
  logic              r_opcode_valid;
  logic              r_halted;

  // The byte returned by memory during WAIT is the one that decides halt vs. execute.
  logic              w_is_halt;
  assign w_is_halt = (i_mem_data == HALT_OPCODE);

  // Sequencer: state, PC, instruction register and its valid/halt flags all advance together.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_opcode       <= 8'h00;
      r_opcode_valid <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          // Read strobe is out this cycle; data arrives for sampling at the end of WAIT.
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_opcode       <= i_mem_data;
          r_pc           <= r_pc + 1'b1;
          r_opcode_valid <= 1'b1;
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // A jump is only honoured alongside completion; a lone i_pc_load is dropped.
          if (i_next_instr) begin
            r_opcode_valid <= 1'b0;
            r_state        <= S_FETCH;
            if (i_pc_load) begin
              r_pc <= i_pc_value;
            end
          end
        end
        S_HALT: begin
          // Terminal: the halt opcode stays presented with valid until reset.
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory interface is decoded from state so the read goes out in the FETCH cycle itself.
  assign o_mem_rd       = (r_state == S_FETCH);
  assign o_mem_addr     = r_pc;
  assign o_pc           = r_pc;
  assign o_opcode       = r_opcode;
  assign o_opcode_valid = r_opcode_valid;
  assign o_halted       = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level PC/memory model with randomized hold times, jumps and ignored requests.
// Latency: checks the 3-cycle fetch window cycle by cycle after every accepted completion.
// Backpressure: random i_next_instr/i_pc_load noise outside EXEC must leave PC and sequencing untouched.
module tb_fetch_unit;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_next_instr;
  logic       i_pc_load;
  logic [7:0] i_pc_value;
  logic [7:0] o_mem_addr;
  logic       o_mem_rd;
  logic [7:0] i_mem_data;
  logic [7:0] o_opcode;
  logic       o_opcode_valid;
  logic [7:0] o_pc;
  logic       o_halted;

  always #5 i_clk = ~i_clk;

  fetch_unit #(
    .ADDR_W     (8),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_next_instr  (i_next_instr),
    .i_pc_load     (i_pc_load),
    .i_pc_value    (i_pc_value),
    .o_mem_addr    (o_mem_addr),
    .o_mem_rd      (o_mem_rd),
    .i_mem_data    (i_mem_data),
    .o_opcode      (o_opcode),
    .o_opcode_valid(o_opcode_valid),
    .o_pc          (o_pc),
    .o_halted      (o_halted)
  );

  // Synchronous program memory: data for a read is available the cycle after the strobe.
  logic [7:0] mem [0:255];
  always @(posedge i_clk) begin
    if (o_mem_rd) i_mem_data <= mem[o_mem_addr];
  end

  int         errors = 0;
  int         checks = 0;
  int         pc_m;     // model PC: address of the next fetch
  logic [7:0] cur_op;   // model instruction register

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic noise();
    i_next_instr = 1'($urandom_range(0, 1));
    i_pc_load    = 1'($urandom_range(0, 1));
    i_pc_value   = 8'($urandom);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"},  32'(o_opcode_valid), 32'd0);
    chk({tag, "_opcode"}, 32'(o_opcode),       32'h00);
    chk({tag, "_rd"},     32'(o_mem_rd),       32'd0);
    chk({tag, "_halted"}, 32'(o_halted),       32'd0);
    chk({tag, "_pc"},     32'(o_pc),           32'h00);
    chk({tag, "_addr"},   32'(o_mem_addr),     32'h00);
  endtask

  // Called just after the WAIT->EXEC/HALT edge: the model consumes one byte at pc_m.
  task automatic expect_capture(input string tag);
    logic [7:0] op;
    op   = mem[pc_m];
    pc_m = (pc_m + 1) % 256;
    chk({tag, "_opcode"}, 32'(o_opcode),       32'(op));
    chk({tag, "_valid"},  32'(o_opcode_valid), 32'd1);
    chk({tag, "_pc"},     32'(o_pc),           32'(pc_m));
    chk({tag, "_halted"}, 32'(o_halted),       32'(op == 8'hFF));
    cur_op = op;
  endtask

  task automatic startup();
    i_rstn       = 1'b0;
    i_next_instr = 1'b0;
    i_pc_load    = 1'b0;
    @(negedge i_clk);
    check_reset("rst");
    @(negedge i_clk);
    i_rstn = 1'b1;
    pc_m   = 0;
    step();
    chk("start_rd",    32'(o_mem_rd),       32'd1);
    chk("start_addr",  32'(o_mem_addr),     32'(pc_m));
    chk("start_valid", 32'(o_opcode_valid), 32'd0);
    step();
    chk("start_wait_rd",    32'(o_mem_rd),       32'd0);
    chk("start_wait_valid", 32'(o_opcode_valid), 32'd0);
    step();
    expect_capture("start_cap");
  endtask

  // One instruction from EXEC: hold, completion (optionally a jump), then the 2-cycle refetch.
  task automatic run_instr(input int hold, input bit jump, input logic [7:0] tgt, input bit abort);
    for (int i = 0; i < hold; i++) begin
      i_next_instr = 1'b0;
      i_pc_load    = 1'($urandom_range(0, 1));
      i_pc_value   = 8'($urandom);
      step();
      chk("exec_valid",   32'(o_opcode_valid), 32'd1);
      chk("exec_hold_op", 32'(o_opcode),       32'(cur_op));
      chk("exec_pc",      32'(o_pc),           32'(pc_m));
      chk("exec_rd",      32'(o_mem_rd),       32'd0);
    end
    i_next_instr = 1'b1;
    i_pc_load    = jump;
    i_pc_value   = tgt;
    step();
    if (jump) pc_m = tgt;
    chk("fetch_valid", 32'(o_opcode_valid), 32'd0);
    chk("fetch_rd",    32'(o_mem_rd),       32'd1);
    chk("fetch_addr",  32'(o_mem_addr),     32'(pc_m));
    chk("fetch_op",    32'(o_opcode),       32'(cur_op));
    noise();
    step();
    chk("wait_valid", 32'(o_opcode_valid), 32'd0);
    chk("wait_rd",    32'(o_mem_rd),       32'd0);
    chk("wait_pc",    32'(o_pc),           32'(pc_m));
    chk("wait_op",    32'(o_opcode),       32'(cur_op));
    if (abort) begin
      #2;
      i_rstn = 1'b0;
      #1;
      check_reset("abort");
      return;
    end
    noise();
    step();
    expect_capture("cap");
    i_next_instr = 1'b0;
    i_pc_load    = 1'b0;
  endtask

  logic [7:0] stream [0:19];

  initial begin
    i_rstn       = 1'b0;
    i_next_instr = 1'b0;
    i_pc_load    = 1'b0;
    i_pc_value   = 8'h00;
    cur_op       = 8'h00;
    pc_m         = 0;

    // Sequential stream ending in the halt opcode.
    stream = '{8'h31, 8'h41, 8'h39, 8'h49, 8'h3B, 8'h4B, 8'h34, 8'h44, 8'h50, 8'h90,
               8'h61, 8'h71, 8'h81, 8'h69, 8'h79, 8'h89, 8'h64, 8'h74, 8'h84, 8'hFF};
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 254));
    for (int a = 0; a < 20; a++) mem[a] = stream[a];

    startup();
    chk("first_opcode", 32'(o_opcode), 32'h31);
    chk("first_pc",     32'(o_pc),     32'd1);
    for (int k = 1; k < 20; k++) run_instr(2, 1'b0, 8'h00, 1'b0);
    chk("halt_flag", 32'(o_halted), 32'd1);
    chk("halt_pc",   32'(o_pc),     32'd20);
    for (int k = 0; k < 4; k++) begin
      noise();
      step();
      chk("halt_hold",  32'(o_halted),       32'd1);
      chk("halt_op",    32'(o_opcode),       32'hFF);
      chk("halt_valid", 32'(o_opcode_valid), 32'd1);
      chk("halt_rd",    32'(o_mem_rd),       32'd0);
      chk("halt_pcst",  32'(o_pc),           32'd20);
    end

    // Reset asserted while a read is in flight.
    startup();
    run_instr(1, 1'b0, 8'h00, 1'b1);

    // Jumps, wrap-around and random traffic over halt-free memory.
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 254));
    mem[8'hFF] = 8'h31;
    mem[8'h00] = 8'h41;
    startup();
    chk("restart_op", 32'(o_opcode), 32'h41);
    while (pc_m != 5) run_instr($urandom_range(0, 3), 1'b0, 8'h00, 1'b0);
    run_instr(0, 1'b1, 8'h40, 1'b0);
    chk("jump_pc", 32'(o_pc), 32'h41);
    run_instr(1, 1'b1, 8'hFF, 1'b0);
    chk("wrap_op", 32'(o_opcode), 32'h31);
    chk("wrap_pc", 32'(o_pc),     32'h00);
    run_instr(0, 1'b0, 8'h00, 1'b0);
    chk("wrap_next_op", 32'(o_opcode), 32'h41);
    for (int k = 0; k < 30; k++) begin
      run_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that drives the opcode input of `control_unit` and consumes its `next_instr` completion pulse. It holds the program counter, reads one opcode byte per instruction from synchronous program memory, presents it on `o_opcode` until the control unit signals completion, then fetches the next one. It also supports PC reload for jumps and a terminal halt opcode.

## Interface
Parameters:
- `ADDR_W`, 8: program counter / memory address width.
- `RESET_PC`, 0: PC value after reset.
- `HALT_OPCODE`, 8'hFF: opcode that halts fetching.

Ports:
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_next_instr`  in  1  completion pulse from `control_unit`; sampled only in EXEC.
- `i_pc_load`  in  1  jump request; sampled only in EXEC, together with `i_next_instr`.
- `i_pc_value`  in  ADDR_W  jump target.
- `o_mem_addr`  out  ADDR_W  program memory address; equals PC.
- `o_mem_rd`  out  1  memory read strobe.
- `i_mem_data`  in  8  read data; valid the cycle after `o_mem_rd`.
- `o_opcode`  out  8  instruction register, to `control_unit.i_opcode`.
- `o_opcode_valid`  out  1  `o_opcode` holds a freshly fetched instruction.
- `o_pc`  out  ADDR_W  current PC (address of the next fetch).
- `o_halted`  out  1  halt opcode reached.

## Operation
- States: IDLE, FETCH, WAIT, EXEC, HALT. Reset state is IDLE.
- IDLE: no read. Unconditionally goes to FETCH.
- FETCH: `o_mem_rd`=1 and `o_mem_addr`=PC. Goes to WAIT.
- WAIT: at the edge, IR<=`i_mem_data`, PC<=PC+1 (wraps from 2^ADDR_W-1 to 0), `o_opcode_valid`<=1.
  - If `i_mem_data`==HALT_OPCODE, go to HALT.
  - Otherwise go to EXEC.
- EXEC: IR held stable.
  - If `i_next_instr`=1: `o_opcode_valid`<=0 and go to FETCH.
  - If `i_pc_load`=1 at the same edge, PC<=`i_pc_value`.
  - `i_pc_load` without `i_next_instr` is ignored.
- HALT: `o_halted`=1 and `o_opcode`=HALT_OPCODE with valid=1. `i_next_instr` and `i_pc_load` are ignored; only reset exits.
- `i_next_instr` and `i_pc_load` are ignored in IDLE, FETCH and WAIT. A pulse arriving there is lost, not queued.
- `o_mem_rd` and `o_mem_addr` are Moore outputs decoded from state and PC. `o_opcode`, `o_opcode_valid` and `o_halted` are registered.

## Timing
- Reset values (asynchronous, immediate on `i_rstn`=0): state=IDLE, PC=RESET_PC, `o_opcode`=8'h00, `o_opcode_valid`=0, `o_mem_rd`=0, `o_halted`=0.
- Startup:
  - First rising edge after reset release enters FETCH.
  - `o_mem_rd` is high in that cycle.
  - The first opcode is valid after the 3rd edge.
- Per-instruction fetch latency:
  - With `i_next_instr` sampled at edge N: FETCH during N..N+1, WAIT during N+1..N+2.
  - The new opcode and valid appear after edge N+2.
  - `o_opcode_valid` is low for exactly 2 cycles between instructions.
- Minimum throughput: 3 cycles per instruction when `i_next_instr` is asserted in the first EXEC cycle.
- `o_opcode` holds its old value while valid is low; it changes only at the WAIT->EXEC/HALT edge.
- `i_next_instr` held high for several cycles counts once per EXEC entry; it is a level sampled only in EXEC.
- Reset asserted mid-fetch aborts the read, and the returning data is not captured.

## Test plan
- Reset/startup: memory {0:8'h31, 1:8'h41}, `i_rstn` released.
  - `o_mem_rd` is high at addr 0 one cycle after release.
  - `o_opcode`=8'h31 with valid=1 after edge 3.
  - `o_pc`=1.
- Sequential stream: load memory with the 19 opcodes 31,41,39,49,3B,4B,34,44,50,90,61,71,81,69,79,89,64,74,84 followed by FF. Pulse `i_next_instr` 2 cycles after each valid.
  - Opcodes are presented in order, each stable until its pulse.
  - Valid is low exactly 2 cycles between opcodes.
  - `o_halted`=1 at FF with `o_pc`=20.
- Jump: in EXEC at PC=5, assert `i_next_instr`=1, `i_pc_load`=1, `i_pc_value`=8'h40.
  - Next `o_mem_addr`=8'h40.
  - `o_pc`=8'h41 after capture.
- Ignored requests: pulse `i_next_instr` and `i_pc_load` during FETCH/WAIT.
  - No state skip, no PC change.
  - Opcode still waits for a pulse in EXEC.
- Wrap-around: RESET_PC=8'hFF, memory[FF]=8'h31, memory[0]=8'h41.
  - After the first capture `o_pc`=8'h00.
  - The next fetch reads addr 0 and yields 8'h41.
- Reset mid-operation: assert `i_rstn`=0 during WAIT.
  - All outputs return to reset values immediately.
  - After release, fetch restarts at RESET_PC.
